// File: rtl/systolic_ctrl_if.sv
// Host-side port bundle for systolic_ctrl: operand loading, start/status and the captured result.
// The master drives loads and start; the slave (controller) returns status and result.
interface systolic_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
);
  logic                    ld_en;
  logic                    ld_sel;
  logic [1:0]              ld_row;
  logic [4*DATA_WIDTH-1:0] ld_data;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [16*ACC_WIDTH-1:0] res_out;

  modport master (
    output ld_en, ld_sel, ld_row, ld_data, start,
    input  busy, done, res_out
  );

  modport slave (
    input  ld_en, ld_sel, ld_row, ld_data, start,
    output busy, done, res_out
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Controller for a 4x4 output-stationary systolic array: buffers A/B rows, clears the array,
// feeds skewed operands for 10 cycles, then captures the 16 accumulators.
module systolic_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  systolic_ctrl_if.slave          host,
  output logic                    arr_we,
  output logic                    arr_clr,
  output logic [4*DATA_WIDTH-1:0] a_in,
  output logic [4*DATA_WIDTH-1:0] b_in,
  input  logic [16*ACC_WIDTH-1:0] res_in
);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;
  localparam logic [3:0] LAST_T = 4'd9;

  state_t                  state_reg, state_next;
  logic [3:0]              t_reg, t_next;
  logic                    we_next, clr_next, feed_next;
  logic [4*DATA_WIDTH-1:0] a_next, b_next;
  logic [DATA_WIDTH-1:0]   a_buf_reg [4][4];
  logic [DATA_WIDTH-1:0]   b_buf_reg [4][4];
  logic [16*ACC_WIDTH-1:0] res_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          a_buf_reg[r][c] <= '0;
          b_buf_reg[r][c] <= '0;
        end
      end
    end else if (state_reg == IDLE && host.ld_en) begin
      for (int c = 0; c < 4; c++) begin
        if (!host.ld_sel) a_buf_reg[host.ld_row][c] <= host.ld_data[c*DATA_WIDTH +: DATA_WIDTH];
        else              b_buf_reg[host.ld_row][c] <= host.ld_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      t_reg     <= '0;
      arr_we    <= 1'b0;
      arr_clr   <= 1'b0;
      a_in      <= '0;
      b_in      <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      arr_we    <= we_next;
      arr_clr   <= clr_next;
      a_in      <= a_next;
      b_in      <= b_next;
      // The last MAC lands on the edge entering DONE, so res_in is settled during DONE.
      if (state_reg == DONE) res_reg <= res_in;
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    we_next    = 1'b0;
    clr_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (host.start) begin
          state_next = CLEAR;
          clr_next   = 1'b1;
        end
      end
      CLEAR: begin
        state_next = FEED;
        t_next     = '0;
        we_next    = 1'b1;
      end
      FEED: begin
        if (t_reg == LAST_T) begin
          state_next = DONE;
          t_next     = '0;
        end else begin
          t_next  = t_reg + 4'd1;
          we_next = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign feed_next = (state_next == FEED);

  // Operand k reaches row/column gi at t = k + gi; outside that window the lane carries zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_skew
      logic [3:0] k;
      logic       lane_valid;
      assign k          = t_next - 4'(gi);
      assign lane_valid = feed_next && (t_next >= 4'(gi)) && (k <= 4'd3);
      assign a_next[gi*DATA_WIDTH +: DATA_WIDTH] = lane_valid ? a_buf_reg[gi][k[1:0]] : '0;
      assign b_next[gi*DATA_WIDTH +: DATA_WIDTH] = lane_valid ? b_buf_reg[k[1:0]][gi] : '0;
    end
  endgenerate

  assign host.busy    = (state_reg != IDLE);
  assign host.done    = (state_reg == DONE);
  assign host.res_out = res_reg;

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the operand element width.
REQ-002 Parameter ACC_WIDTH, default 16, SHALL set the result element width; array size is fixed at 4x4.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 ld_en  input  1  SHALL be the operand-buffer write strobe.
REQ-006 ld_sel  input  1  SHALL select the buffer: 0 = A, 1 = B.
REQ-007 ld_row  input  2  SHALL be the row index written.
REQ-008 ld_data  input  4*DATA_WIDTH  SHALL carry the row; byte c = column c.
REQ-009 start  input  1  SHALL request one matrix multiply C = A x B.
REQ-010 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-011 done  output  1  SHALL pulse high for one cycle when the result is captured.
REQ-012 arr_we  output  1  SHALL drive the array MAC enable.
REQ-013 arr_clr  output  1  SHALL drive the array accumulator synchronous clear.
REQ-014 a_in  output  4*DATA_WIDTH  SHALL drive the row activations; slice i feeds row i.
REQ-015 b_in  output  4*DATA_WIDTH  SHALL drive the column weights; slice j feeds column j.
REQ-016 res_in  input  16*ACC_WIDTH  SHALL carry the array outputs; slice 4*i+j = C[i][j].
REQ-017 res_out  output  16*ACC_WIDTH  SHALL hold the captured result, using the same packing as res_in.

Function
REQ-018 The states SHALL be IDLE, CLEAR, FEED and DONE.
REQ-019 In IDLE, ld_en SHALL write ld_data into A[ld_row] or B[ld_row] at the clock edge.
REQ-020 ld_en SHALL be ignored in any state other than IDLE.
REQ-021 In IDLE, start SHALL move the state to CLEAR; start SHALL be ignored when busy.
REQ-022 When ld_en and start are both high in IDLE, the write SHALL complete and the written data SHALL be used by that operation.
REQ-023 CLEAR SHALL last one cycle with arr_clr=1, arr_we=0, a_in=0, b_in=0, then enter FEED with the 4-bit counter t=0.
REQ-024 FEED SHALL last 10 cycles, t=0..9, with arr_we=1 and arr_clr=0; t increments each cycle.
REQ-025 In FEED, a_in slice i SHALL be A[i][t-i] when 0<=t-i<=3, else 0.
REQ-026 In FEED, b_in slice j SHALL be B[t-j][j] when 0<=t-j<=3, else 0.
REQ-027 a_in and b_in SHALL be zero from t=7 to t=9 (drain of the PE(3,3) wavefront, last MAC at t=9).
REQ-028 After t=9, the state SHALL move to DONE.
REQ-029 In DONE, res_in SHALL be registered into res_out, done SHALL be 1 and arr_we SHALL be 0; the next state is IDLE.
REQ-030 start-to-done latency SHALL be 12 cycles: start sampled at edge 0, done high in the cycle after edge 11.
REQ-031 res_out SHALL hold its value until the next DONE; buffers A and B SHALL hold until overwritten.
REQ-032 start held high continuously SHALL launch back-to-back operations, one every 13 cycles (IDLE cycle included).
REQ-033 a_in, b_in, arr_we and arr_clr SHALL be registered outputs.
REQ-034 The controller SHALL perform no arithmetic on the data; operand bytes SHALL pass through bit-exact.

Reset
REQ-035 Asserting rst_n low at any time, including mid-FEED, SHALL immediately force state=IDLE, t=0, busy=0, done=0, arr_we=0, arr_clr=0, a_in=0, b_in=0, res_out=0 and A=B=0.
REQ-036 After rst_n is released, the first start SHALL behave as in REQ-021.

Verification
REQ-037 Load A=identity, B[k][j]=4k+j+1, pulse start; with the array model connected -> done exactly 12 cycles after start and res_out C[i][j]=4i+j+1.
REQ-038 Check the skew: A all 1s, B all 2s -> at t=0 only a_in slice0 and b_in slice0 are nonzero; at t=3 all slices = 1/2; from t=7 all zero; res_out all 8.
REQ-039 Pulse start during FEED and pulse ld_en to A[0] = 0xFFFFFFFF -> no restart, A unchanged, and the result matches the prior operands.
REQ-040 Assert ld_en (A row 3 = 0x05050505) and start in the same IDLE cycle -> row 3 of the result uses 5s.
REQ-041 Drop rst_n at t=4 -> all outputs 0 asynchronously, busy=0, no done pulse; a new start then runs a full 12 cycles.
REQ-042 Hold start high -> done pulses separated by 13 cycles and arr_clr asserted once per operation.
